// File: rtl/poly_17_or_9_bit_pkg.sv
// Widths and feedback taps shared by the POKEY polynomial noise counter.
// Taps are zero-based bit indices of the state register.
package poly_pkg;

   localparam int LONG_W  = 17;
   localparam int SHORT_W = 9;
   localparam int RAND_W  = 8;

   localparam int POLY17_TAP_A = 16;
   localparam int POLY17_TAP_B = 13;
   localparam int POLY9_TAP_A  = 8;
   localparam int POLY9_TAP_B  = 4;

endpackage

// File: rtl/poly_17_or_9_bit_if.sv
// Mode select and noise outputs of the polynomial counter.
// master drives sel9; slave (the counter) drives out and randNum.
interface poly_17_or_9_bit_if;
   import poly_pkg::*;

   logic              sel9;
   logic              out;
   logic [RAND_W-1:0] randNum;

   modport master (
      output sel9,
      input  out,
      input  randNum
   );

   modport slave (
      input  sel9,
      output out,
      output randNum
   );

endinterface

// File: rtl/poly_17_or_9_bit_step.sv
// One XNOR-LFSR step for a W-bit register with taps TA/TB.
// POLY_LOCKUP_GUARD_EN: all-ones steps to zero instead of sticking.
module poly_17_or_9_bit_step #(
   parameter int W  = 17,
   parameter int TA = 16,
   parameter int TB = 13
) (
   input  logic [W-1:0] s,
   output logic [W-1:0] nxt
);

   logic [W-1:0] shift;

   always_comb begin
      shift = {s[W-2:0], ~(s[TA] ^ s[TB])};
`ifdef POLY_LOCKUP_GUARD_EN
      nxt = (&s) ? '0 : shift;
`else
      nxt = shift;
`endif
   end

endmodule

// File: rtl/poly_17_or_9_bit.sv
// POKEY polynomial noise counter: 17- or 9-bit XNOR LFSR chosen by sel9.
// Optional all-ones recovery with `POLY_LOCKUP_GUARD_EN.
module poly_17_or_9_bit
   import poly_pkg::*;
(
   input  logic              clk,
   input  logic              init_L,
   poly_17_or_9_bit_if.slave bus
);

   logic [LONG_W-1:0]  s_q;
   logic [LONG_W-1:0]  s_d;
   logic [LONG_W-1:0]  nxt_long;
   logic [SHORT_W-1:0] nxt_short;

   poly_17_or_9_bit_step #(
      .W  (LONG_W),
      .TA (POLY17_TAP_A),
      .TB (POLY17_TAP_B)
   ) u_long (
      .s   (s_q),
      .nxt (nxt_long)
   );

   poly_17_or_9_bit_step #(
      .W  (SHORT_W),
      .TA (POLY9_TAP_A),
      .TB (POLY9_TAP_B)
   ) u_short (
      .s   (s_q[SHORT_W-1:0]),
      .nxt (nxt_short)
   );

   // Short mode keeps the upper bits cleared so 9->17 resumes cleanly
   always_comb begin
      s_d = nxt_long;
      if (bus.sel9) begin
         s_d = {{(LONG_W-SHORT_W){1'b0}}, nxt_short};
      end
   end

   always_ff @(posedge clk or negedge init_L) begin
      if (!init_L) begin
         s_q <= '0;
      end else begin
         s_q <= s_d;
      end
   end

   assign bus.out = bus.sel9 ? s_q[SHORT_W-1]
                             : s_q[LONG_W-1];
   assign bus.randNum = s_q[RAND_W-1:0];

endmodule

// File: tb/tb_poly_17_or_9_bit.sv
// Directed tables and sequences for the polynomial noise counter.
// A small reference model predicts state across mode switches.
module tb_poly_17_or_9_bit;

   logic clk;
   logic init_L;
   int   total;
   int   bad;

   poly_17_or_9_bit_if bus ();

   poly_17_or_9_bit dut (
      .clk    (clk),
      .init_L (init_L),
      .bus    (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       sel9;
      logic [7:0] rnd;
      logic       o;
   } vec_t;

   vec_t tbl[17];

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic [16:0] mstep(input logic [16:0] s,
                                         input logic sel9);
      logic [16:0] n;
      n = '0;
      if (sel9) begin
         n[8:1] = s[7:0];
         n[0]   = ~(s[8] ^ s[4]);
`ifdef POLY_LOCKUP_GUARD_EN
         if (s[8:0] == 9'h1FF) n = '0;
`endif
      end else begin
         n = {s[15:0], ~(s[16] ^ s[13])};
`ifdef POLY_LOCKUP_GUARD_EN
         if (s == 17'h1FFFF) n = '0;
`endif
      end
      return n;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic sel);
      @(negedge clk);
      bus.sel9 = sel;
      init_L = 1'b0;
      @(negedge clk);
      init_L = 1'b1;
   endtask

   initial begin
      logic [16:0] m;
      int          n;
      int          ones;
      total = 0;
      bad = 0;
      init_L = 1'b0;
      bus.sel9 = 1'b0;

      tbl[0]  = '{1, 0, 8'h01, 0};
      tbl[1]  = '{0, 0, 8'h03, 0};
      tbl[2]  = '{0, 0, 8'h07, 0};
      tbl[3]  = '{0, 0, 8'h0F, 0};
      tbl[4]  = '{0, 0, 8'h1F, 0};
      tbl[5]  = '{0, 0, 8'h3F, 0};
      tbl[6]  = '{0, 0, 8'h7F, 0};
      tbl[7]  = '{0, 0, 8'hFF, 0};
      tbl[8]  = '{1, 1, 8'h01, 0};
      tbl[9]  = '{0, 1, 8'h03, 0};
      tbl[10] = '{0, 1, 8'h07, 0};
      tbl[11] = '{0, 1, 8'h0F, 0};
      tbl[12] = '{0, 1, 8'h1F, 0};
      tbl[13] = '{0, 1, 8'h3E, 0};
      tbl[14] = '{0, 1, 8'h7C, 0};
      tbl[15] = '{0, 1, 8'hF8, 0};
      tbl[16] = '{0, 1, 8'hF0, 1};

      #2;
      chk("reset_rand", 32'(bus.randNum), 32'h00);
      chk("reset_out", 32'(bus.out), 32'h0);

      for (int i = 0; i < 17; i++) begin
         if (tbl[i].rst) do_reset(tbl[i].sel9);
         step();
         chk($sformatf("tbl%0d_rand", i),
             32'(bus.randNum), 32'(tbl[i].rnd));
         chk($sformatf("tbl%0d_out", i),
             32'(bus.out), 32'(tbl[i].o));
      end

      // 9-bit period from reset
      do_reset(1'b1);
      n = 0;
      ones = 0;
      for (int i = 0; i < 600; i++) begin
         step();
         n++;
         if (dut.s_q[8:0] == 9'h1FF) ones++;
         if (dut.s_q == 17'h0) break;
      end
      chk("period9", 32'(n), 32'd511);
      chk("period9_no_ones", 32'(ones), 32'd0);

      // 17-bit wrap: step 131070 from reset must lead back to zero
      m = '0;
      for (int i = 0; i < 131070; i++) m = mstep(m, 1'b0);
      @(negedge clk);
      bus.sel9 = 1'b0;
      force dut.s_q = m;
      #1;
      chk("wrap17_next", 32'(dut.s_d), 32'h0);
      release dut.s_q;

      // mixed-mode run against the model
      do_reset(1'b0);
      m = '0;
      for (int i = 0; i < 400; i++) begin
         step();
         m = mstep(m, bus.sel9);
         if (dut.s_q !== m || bus.randNum !== m[7:0] ||
             bus.out !== (bus.sel9 ? m[8] : m[16]) || i % 50 == 0) begin
            chk($sformatf("mix%0d_s", i), 32'(dut.s_q), 32'(m));
            chk($sformatf("mix%0d_out", i), 32'(bus.out),
                32'(bus.sel9 ? m[8] : m[16]));
         end
         bus.sel9 = ((i / 37) % 2) == 1;
      end

      // async init mid-run in 9-bit mode
      do_reset(1'b1);
      for (int i = 0; i < 100; i++) step();
      #2;
      init_L = 1'b0;
      #1;
      chk("async_rand", 32'(bus.randNum), 32'h00);
      chk("async_out", 32'(bus.out), 32'h0);
      @(negedge clk);
      init_L = 1'b1;
      #1;
      chk("async_hold", 32'(dut.s_q), 32'h0);
      step();
      chk("async_first", 32'(bus.randNum), 32'h01);

      // 17 -> 9 switch after 20 clocks
      do_reset(1'b0);
      m = '0;
      for (int i = 0; i < 20; i++) begin
         step();
         m = mstep(m, 1'b0);
      end
      chk("pre_sw_s", 32'(dut.s_q), 32'(m));
      bus.sel9 = 1'b1;
      step();
      m = mstep(m, 1'b1);
      chk("sw_upper", 32'(dut.s_q[16:9]), 32'h0);
      chk("sw_low", 32'(dut.s_q[8:0]), 32'(m[8:0]));
      chk("sw_out", 32'(bus.out), 32'(m[8]));

      // 9 -> 17 continues from the short state
      bus.sel9 = 1'b0;
      step();
      m = mstep(m, 1'b0);
      chk("sw17_s", 32'(dut.s_q), 32'(m));

      // lockup behaviour
      @(negedge clk);
      bus.sel9 = 1'b0;
      force dut.s_q = 17'h1FFFF;
      #1;
`ifdef POLY_LOCKUP_GUARD_EN
      chk("lock17", 32'(dut.s_d), 32'h0);
`else
      chk("lock17", 32'(dut.s_d), 32'h1FFFF);
`endif
      bus.sel9 = 1'b1;
      force dut.s_q = 17'h001FF;
      #1;
`ifdef POLY_LOCKUP_GUARD_EN
      chk("lock9", 32'(dut.s_d), 32'h0);
`else
      chk("lock9", 32'(dut.s_d), 32'h001FF);
`endif
      release dut.s_q;
      init_L = 1'b0;
      #1;
      init_L = 1'b1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
